des_rx_block_packer: RTL
========================

# des_rx_block_packer

Packs bytes from the UART receiver into 64-bit plaintext blocks for the DES core. Sits between the UART receive path and the DES datapath input. It collects eight received bytes MSB-first into one block and holds finished blocks behind a valid/ready handshake. It discards partial blocks on a parity error or on an inter-byte timeout, so the DES core never sees a misaligned block.

## Interface
Parameters:
- TIMEOUT_CYCLES, 200000: idle CLK cycles allowed between bytes of one partial block (about 4 byte-times at 9600 baud, 50 MHz); 0 disables the timeout.
- TO_W, 18: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock; all logic is rising-edge.
- RST  in  1  reset, asynchronous, active-high.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe: rx_data is a new byte.
- rx_perr  in  1  parity error for the byte strobed this cycle; sampled only when rx_valid=1.
- block_data  out  [64:1]  assembled block; bit 64 is the MSB of the first byte received.
- block_valid  out  1  block_data holds an unconsumed block.
- block_ready  in  1  DES side accepts block_data this cycle when block_valid=1.
- overrun  out  1  one-cycle pulse: a byte was dropped because both block stores were full.
- frame_drop  out  1  one-cycle pulse: a partial block was discarded (parity error or timeout).
- byte_cnt  out  4  bytes held in the assembly register, 0..8.

## Operation
- Storage: the assembly register asm[64:1] with byte_cnt, plus the output register (block_data / block_valid). Together they give two-block buffering.
- States:
  - IDLE: byte_cnt=0.
  - FILL: byte_cnt 1..7.
  - FULL: byte_cnt=8, a complete block is waiting for the output register.
- Good byte (rx_valid=1, rx_perr=0) in IDLE/FILL: asm <= {asm[56:1], rx_data}, byte_cnt+1.
- Byte order: first byte ends in bits [64:57], eighth byte in bits [8:1].
- The output register is free when block_valid=0, or when block_valid=1 and block_ready=1 in the same cycle.
- 8th good byte with the output register free: the completed block goes straight to block_data, block_valid<=1, byte_cnt<=0.
- 8th good byte with the output register not free: go to FULL.
- FULL: moves to the output register on the first cycle it is free, then byte_cnt<=0.
  - A good byte arriving in that same cycle becomes byte 1 of the next block, with no overrun.
  - A byte arriving in FULL when no transfer happens is dropped and overrun pulses.
- Bad byte (rx_valid=1, rx_perr=1):
  - In FILL or IDLE: byte discarded, asm partial discarded, byte_cnt<=0, frame_drop pulses.
  - In FULL: the byte is dropped with an overrun pulse; the stored block is kept.
- Timeout:
  - A counter runs only in FILL and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES: byte_cnt<=0, frame_drop pulses.
  - If a byte arrives in the same cycle as expiry, the byte wins and the counter restarts.
- block_data is stable while block_valid=1 and block_ready=0.
- block_valid falls only after a handshake cycle with no replacement block.

## Timing
- Reset values: block_data=0, block_valid=0, overrun=0, frame_drop=0, byte_cnt=0; asm and timeout counter cleared.
- RST asserted mid-block or mid-handshake discards all held data immediately, without waiting for a clock edge.
- Latency: block_valid=1 on the rising edge that samples the 8th rx_valid, when the output register is free.
- Throughput: one block per cycle at the handshake. Back-to-back handshakes with a FULL block produce no bubble cycle.
- overrun and frame_drop are registered, asserted for exactly one cycle, never concurrently.
- byte_cnt is registered and reflects the state after each edge.

## Test plan
- Basic block: bytes 01,02,...,08 on rx_valid, block_ready=1 → block_data=0102030405060708 with block_valid for 1 cycle after the 8th byte; byte_cnt returns to 0.
- Backpressure: block_ready=0, send 16 bytes 00..0F → block_data=0001020304050607, byte_cnt=8. A 17th byte gives one overrun pulse and byte_cnt stays 8. Raising block_ready → 08090A0B0C0D0E0F on the next edge with no idle cycle.
- Parity error: bytes AA,BB,CC, then DD with rx_perr=1 → frame_drop pulse, byte_cnt=0. The next 8 bytes 11..88 form block 1122334455667788.
- Timeout with TIMEOUT_CYCLES=100: 3 bytes then idle → frame_drop exactly 100 cycles after the 3rd byte, byte_cnt=0. A byte on cycle 99 restarts the count instead.
- Simultaneous events: FULL with block_ready=1 and a good byte in the same cycle → block transferred, byte_cnt=1, no overrun.
- Reset mid-fill: 5 bytes, then RST pulse → all outputs 0 immediately. The next 8 bytes produce a correctly aligned block.

Source files
------------

// File: rtl/des_rx_block_packer.sv
// ============================================================================
// Module   : des_rx_block_packer
// Brief    : Packs UART bytes MSB-first into 64-bit DES blocks with two-block
//            buffering; drops partial blocks on parity error or idle timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module des_rx_block_packer #(
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned TO_W           = 18
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_perr,
  output logic [64:1] block_data,
  output logic        block_valid,
  input  logic        block_ready,
  output logic        overrun,
  output logic        frame_drop,
  output logic [3:0]  byte_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } state_t;

  localparam bit            c_to_en   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] c_to_last =
    TO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t            r_state,       w_state;
  logic [64:1]       r_asm,         w_asm;
  logic [3:0]        r_byte_cnt,    w_byte_cnt;
  logic [TO_W-1:0]   r_to_cnt,      w_to_cnt;
  logic [64:1]       r_block_data,  w_block_data;
  logic              r_block_valid, w_block_valid;
  logic              r_overrun,     w_overrun;
  logic              r_frame_drop,  w_frame_drop;

  logic        w_good;
  logic        w_bad;
  logic        w_out_free;
  logic [64:1] w_asm_shift;

  assign w_good      = rx_valid & ~rx_perr;
  assign w_bad       = rx_valid &  rx_perr;
  assign w_out_free  = ~r_block_valid | block_ready;
  assign w_asm_shift = {r_asm[56:1], rx_data};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_asm         <= '0;
      r_byte_cnt    <= '0;
      r_to_cnt      <= '0;
      r_block_data  <= '0;
      r_block_valid <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_drop  <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_asm         <= w_asm;
      r_byte_cnt    <= w_byte_cnt;
      r_to_cnt      <= w_to_cnt;
      r_block_data  <= w_block_data;
      r_block_valid <= w_block_valid;
      r_overrun     <= w_overrun;
      r_frame_drop  <= w_frame_drop;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_asm         = r_asm;
    w_byte_cnt    = r_byte_cnt;
    w_to_cnt      = r_to_cnt;
    w_block_data  = r_block_data;
    // A handshake empties the output register unless a block replaces it below.
    w_block_valid = r_block_valid & ~block_ready;
    w_overrun     = 1'b0;
    w_frame_drop  = 1'b0;

    case (r_state)
      S_IDLE, S_FILL: begin
        if (w_good) begin
          w_asm    = w_asm_shift;
          w_to_cnt = '0;
          if (r_byte_cnt == 4'd7) begin
            if (w_out_free) begin
              w_block_data  = w_asm_shift;
              w_block_valid = 1'b1;
              w_byte_cnt    = 4'd0;
              w_state       = S_IDLE;
            end else begin
              w_byte_cnt = 4'd8;
              w_state    = S_FULL;
            end
          end else begin
            w_byte_cnt = r_byte_cnt + 4'd1;
            w_state    = S_FILL;
          end
        end else if (w_bad) begin
          w_asm        = '0;
          w_byte_cnt   = 4'd0;
          w_to_cnt     = '0;
          w_frame_drop = 1'b1;
          w_state      = S_IDLE;
        end else if ((r_state == S_FILL) && c_to_en) begin
          if (r_to_cnt == c_to_last) begin
            w_asm        = '0;
            w_byte_cnt   = 4'd0;
            w_to_cnt     = '0;
            w_frame_drop = 1'b1;
            w_state      = S_IDLE;
          end else begin
            w_to_cnt = r_to_cnt + 1'b1;
          end
        end
      end

      S_FULL: begin
        if (w_out_free) begin
          // Stored block moves out; a byte arriving now is handled as in IDLE.
          w_block_data  = r_asm;
          w_block_valid = 1'b1;
          w_to_cnt      = '0;
          if (w_good) begin
            w_asm      = w_asm_shift;
            w_byte_cnt = 4'd1;
            w_state    = S_FILL;
          end else begin
            w_asm      = '0;
            w_byte_cnt = 4'd0;
            w_state    = S_IDLE;
            if (w_bad) begin
              w_frame_drop = 1'b1;
            end
          end
        end else if (rx_valid) begin
          w_overrun = 1'b1;
        end
      end

      default: begin
        w_state    = S_IDLE;
        w_byte_cnt = 4'd0;
      end
    endcase
  end

  assign block_data  = r_block_data;
  assign block_valid = r_block_valid;
  assign overrun     = r_overrun;
  assign frame_drop  = r_frame_drop;
  assign byte_cnt    = r_byte_cnt;

endmodule

`default_nettype wire
